ysyx_25060170_exu_mc: RTL and testbench

Parametrised multi-cycle execute unit, the successor to the single-cycle EXU. Sits between IDU and WBU and adds valid/ready handshakes on both sides. Supports the full RV32I ALU set plus iterative unsigned/low multiply and signed/unsigned divide/remainder (RV32M subset). Computes the jal/jalr jump target alongside the result and holds both until WBU accepts them.

---
 rtl/ysyx_25060170_exu_mc.sv | 165 ++++++++++++++++
 tb/tb_ysyx_25060170_exu_mc.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25060170_exu_mc.sv
// Multi-cycle execute unit. It handles RV32I ALU ops, a shift-add multiplier and a
// restoring divider, with valid/ready handshakes toward IDU and WBU.
//
// state | meaning
// IDLE  | in_ready high, waiting for an operation from IDU
// MUL   | shift-add multiply, one multiplier bit per cycle
// DIV   | restoring divide, one quotient bit per cycle
// DONE  | out_valid high, result held until WBU takes it
module ysyx_25060170_exu_mc #(
    parameter int XLEN = 32,
    parameter bit M_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            flush,
    input  logic [3:0]      alu_op,
    input  logic [XLEN-1:0] exu_op_1,
    input  logic [XLEN-1:0] exu_op_2,
    input  logic [XLEN-1:0] imm,
    input  logic            exu_is_jal,
    input  logic            exu_is_jalr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] exu_res,
    output logic [XLEN-1:0] jump_addr
);
    localparam int SW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
    state_t state, state_nxt;

    logic [SW-1:0]     cnt;
    logic [3:0]        op;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   mcand;
    logic [XLEN-1:0]   dvd_q, dvs, rem;
    logic              neg_q, neg_r;

    logic            accept, last_iter;
    logic            is_mul, is_div, div_signed, div_zero, div_ovf, div_fast;
    logic [SW-1:0]   shamt;
    logic [XLEN-1:0] imm_res, jsum, op1_abs, op2_abs;
    logic [XLEN:0]   msum;
    logic [2*XLEN-1:0] acc_nxt;
    logic [XLEN:0]   r_sh;
    logic            q_bit;
    logic [XLEN-1:0] rem_nxt, q_nxt, q_fin, r_fin;

    assign in_ready   = (state == IDLE);
    assign out_valid  = (state == DONE);
    assign accept     = in_valid && in_ready && !flush;
    assign last_iter  = (cnt == '0);

    assign is_mul     = M_EN && (alu_op == 4'd10 || alu_op == 4'd11);
    assign is_div     = M_EN && (alu_op >= 4'd12);
    assign div_signed = (alu_op == 4'd12 || alu_op == 4'd14);
    assign div_zero   = (exu_op_2 == '0);
    assign div_ovf    = div_signed && (exu_op_1 == MIN) && (exu_op_2 == '1);
    assign div_fast   = div_zero || div_ovf;
    assign shamt      = exu_op_2[SW-1:0];
    assign jsum       = imm + exu_op_1;
    assign op1_abs    = (div_signed && exu_op_1[XLEN-1]) ? -exu_op_1 : exu_op_1;
    assign op2_abs    = (div_signed && exu_op_2[XLEN-1]) ? -exu_op_2 : exu_op_2;

    // Single-cycle results, including the divide special cases.
    always_comb begin
        imm_res = '0;
        case (alu_op)
            4'd0:  imm_res = exu_op_1 + exu_op_2;
            4'd1:  imm_res = exu_op_1 - exu_op_2;
            4'd2:  imm_res = exu_op_1 & exu_op_2;
            4'd3:  imm_res = exu_op_1 | exu_op_2;
            4'd4:  imm_res = exu_op_1 ^ exu_op_2;
            4'd5:  imm_res = exu_op_1 << shamt;
            4'd6:  imm_res = exu_op_1 >> shamt;
            4'd7:  imm_res = XLEN'($signed(exu_op_1) >>> shamt);
            4'd8:  imm_res = {{(XLEN-1){1'b0}}, $signed(exu_op_1) < $signed(exu_op_2)};
            4'd9:  imm_res = {{(XLEN-1){1'b0}}, exu_op_1 < exu_op_2};
            4'd12, 4'd13: if (M_EN) imm_res = div_zero ? '1 : MIN;
            4'd14, 4'd15: if (M_EN) imm_res = div_zero ? exu_op_1 : '0;
            default: imm_res = '0;
        endcase
    end

    // One multiply step and one restoring-divide step.
    always_comb begin
        msum    = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? mcand : {XLEN{1'b0}})};
        acc_nxt = {msum, acc[XLEN-1:1]};
        r_sh    = {rem, dvd_q[XLEN-1]};
        q_bit   = (r_sh >= {1'b0, dvs});
        rem_nxt = q_bit ? XLEN'(r_sh - {1'b0, dvs}) : r_sh[XLEN-1:0];
        q_nxt   = {dvd_q[XLEN-2:0], q_bit};
        q_fin   = neg_q ? -q_nxt : q_nxt;
        r_fin   = neg_r ? -rem_nxt : rem_nxt;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; flush always returns to IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) begin
                if (is_mul)                   state_nxt = MUL;
                else if (is_div && !div_fast) state_nxt = DIV;
                else                          state_nxt = DONE;
            end
            MUL, DIV: if (flush)    state_nxt = IDLE;
                      else if (last_iter) state_nxt = DONE;
            DONE: if (flush || out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, iteration datapath and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            op        <= '0;
            acc       <= '0;
            mcand     <= '0;
            dvd_q     <= '0;
            dvs       <= '0;
            rem       <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            exu_res   <= '0;
            jump_addr <= '0;
        end else if (state == IDLE) begin
            if (accept) begin
                op    <= alu_op;
                cnt   <= SW'(XLEN-1);
                acc   <= {{XLEN{1'b0}}, exu_op_2};
                mcand <= exu_op_1;
                dvd_q <= op1_abs;
                dvs   <= op2_abs;
                rem   <= '0;
                neg_q <= div_signed && (exu_op_1[XLEN-1] ^ exu_op_2[XLEN-1]);
                neg_r <= div_signed && exu_op_1[XLEN-1];
                if (exu_is_jalr)     jump_addr <= {jsum[XLEN-1:1], 1'b0};
                else if (exu_is_jal) jump_addr <= jsum;
                else                 jump_addr <= '0;
                if (state_nxt == DONE) exu_res <= imm_res;
            end
        end else if (state == MUL && !flush) begin
            acc <= acc_nxt;
            cnt <= cnt - SW'(1);
            if (last_iter)
                exu_res <= (op == 4'd10) ? acc_nxt[XLEN-1:0] : acc_nxt[2*XLEN-1:XLEN];
        end else if (state == DIV && !flush) begin
            rem   <= rem_nxt;
            dvd_q <= q_nxt;
            cnt   <= cnt - SW'(1);
            if (last_iter)
                exu_res <= (op == 4'd12 || op == 4'd13) ? q_fin : r_fin;
        end
    end
endmodule

// File: tb/tb_ysyx_25060170_exu_mc.sv
// Directed bench for the multi-cycle execute unit with XLEN=32, M_EN=1.
module tb_ysyx_25060170_exu_mc;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        flush = 1'b0;
    logic [3:0]  alu_op = '0;
    logic [31:0] exu_op_1 = '0, exu_op_2 = '0, imm = '0;
    logic        exu_is_jal = 1'b0, exu_is_jalr = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] exu_res, jump_addr;

    int passed = 0;
    int total  = 0;

    ysyx_25060170_exu_mc #(.XLEN(32), .M_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .alu_op(alu_op), .exu_op_1(exu_op_1), .exu_op_2(exu_op_2), .imm(imm),
        .exu_is_jal(exu_is_jal), .exu_is_jalr(exu_is_jalr), .out_valid(out_valid),
        .out_ready(out_ready), .exu_res(exu_res), .jump_addr(jump_addr)
    );

    always #5 clk = ~clk;

    // Drives one operation, waits for out_valid (bounded), returns result and latency,
    // then hands it to the consumer with a single out_ready cycle.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] im, input logic jal, input logic jalr,
                          output logic [31:0] res, output logic [31:0] ja, output int lat);
        alu_op = op; exu_op_1 = a; exu_op_2 = b; imm = im;
        exu_is_jal = jal; exu_is_jalr = jalr; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; exu_is_jal = 1'b0; exu_is_jalr = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) lat = -1;
        res = exu_res; ja = jump_addr;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else passed++;
        total++; if (exu_res !== 32'h0) $display("FAIL reset_exu_res got=%h exp=0", exu_res); else passed++;
        total++; if (jump_addr !== 32'h0) $display("FAIL reset_jump_addr got=%h exp=0", jump_addr); else passed++;
    endtask

    task automatic test_alu;
        logic [3:0]  ops [9]  = '{4'd0, 4'd1, 4'd7, 4'd8, 4'd9, 4'd5, 4'd6, 4'd4, 4'd2};
        logic [31:0] as  [9]  = '{32'h7FFFFFFF, 32'h0, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                  32'h1, 32'h80000000, 32'hF0F0F0F0, 32'hFF00FF00};
        logic [31:0] bs  [9]  = '{32'h1, 32'h1, 32'h4, 32'h1, 32'h1, 32'd33, 32'h4, 32'hFFFF0000, 32'h0FF00FF0};
        logic [31:0] exp [9]  = '{32'h80000000, 32'hFFFFFFFF, 32'hF8000000, 32'h1, 32'h0,
                                  32'h2, 32'h08000000, 32'h0F0FF0F0, 32'h0F000F00};
        logic [31:0] res, ja;
        int lat;
        for (int i = 0; i < 9; i++) begin
            run_op(ops[i], as[i], bs[i], 32'h0, 1'b0, 1'b0, res, ja, lat);
            total++; if (res !== exp[i]) $display("FAIL alu_%0d_res got=%h exp=%h", i, res, exp[i]); else passed++;
            total++; if (lat !== 1) $display("FAIL alu_%0d_latency got=%0d exp=1", i, lat); else passed++;
        end
    endtask

    task automatic test_mul;
        logic [3:0]  ops [3] = '{4'd10, 4'd11, 4'd10};
        logic [31:0] as  [3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd12345};
        logic [31:0] bs  [3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1000};
        logic [31:0] exp [3] = '{32'h00000001, 32'hFFFFFFFE, 32'd12345000};
        logic [31:0] res, ja;
        int lat;
        for (int i = 0; i < 3; i++) begin
            run_op(ops[i], as[i], bs[i], 32'h0, 1'b0, 1'b0, res, ja, lat);
            total++; if (res !== exp[i]) $display("FAIL mul_%0d_res got=%h exp=%h", i, res, exp[i]); else passed++;
            total++; if (lat !== 33) $display("FAIL mul_%0d_latency got=%0d exp=33", i, lat); else passed++;
        end
    endtask

    task automatic test_div;
        logic [3:0]  ops  [10] = '{4'd12, 4'd14, 4'd13, 4'd15, 4'd12, 4'd14, 4'd13, 4'd15, 4'd14, 4'd12};
        logic [31:0] as   [10] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd7, 32'd7, 32'h80000000, 32'h80000000,
                                   32'd100, 32'd100, 32'd7, 32'd7};
        logic [31:0] bs   [10] = '{32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                   32'd7, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFE};
        logic [31:0] exp  [10] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd7, 32'h80000000, 32'h0,
                                   32'd14, 32'd2, 32'd1, 32'hFFFFFFFD};
        int          elat [10] = '{33, 33, 1, 1, 1, 1, 33, 33, 33, 33};
        logic [31:0] res, ja;
        int lat;
        for (int i = 0; i < 10; i++) begin
            run_op(ops[i], as[i], bs[i], 32'h0, 1'b0, 1'b0, res, ja, lat);
            total++; if (res !== exp[i]) $display("FAIL div_%0d_res got=%h exp=%h", i, res, exp[i]); else passed++;
            total++; if (lat !== elat[i]) $display("FAIL div_%0d_latency got=%0d exp=%0d", i, lat, elat[i]); else passed++;
        end
    endtask

    task automatic test_jump;
        logic        jals  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic        jalrs [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [31:0] exp   [4] = '{32'h80000002, 32'h80000003, 32'h0, 32'h80000002};
        logic [31:0] res, ja;
        int lat;
        for (int i = 0; i < 4; i++) begin
            run_op(4'd0, 32'h80000000, 32'h4, 32'd3, jals[i], jalrs[i], res, ja, lat);
            total++; if (ja !== exp[i]) $display("FAIL jump_%0d_addr got=%h exp=%h", i, ja, exp[i]); else passed++;
        end
    endtask

    task automatic test_stall;
        int bad = 0;
        alu_op = 4'd0; exu_op_1 = 32'd5; exu_op_2 = 32'd6; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || exu_res !== 32'd11) begin
                $display("FAIL stall_cycle_%0d got ov=%b ir=%b res=%h exp ov=1 ir=0 res=0000000b",
                         i, out_valid, in_ready, exu_res);
                bad++;
            end
            @(posedge clk); #1;
        end
        total++; if (bad != 0) $display("FAIL stall_hold got=%0d bad cycles exp=0", bad); else passed++;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0) $display("FAIL stall_release_ov got=%b exp=0", out_valid); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL stall_release_ir got=%b exp=1", in_ready); else passed++;
    endtask

    task automatic test_flush;
        int pulses = 0;
        alu_op = 4'd10; exu_op_1 = 32'd3; exu_op_2 = 32'd4; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++; if (in_ready !== 1'b0) $display("FAIL mul_busy_in_ready got=%b exp=0", in_ready); else passed++;
        repeat (10) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        total++; if (in_ready !== 1'b1) $display("FAIL flush_mul_idle got=%b exp=1", in_ready); else passed++;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) pulses++;
            @(posedge clk); #1;
        end
        total++; if (pulses != 0) $display("FAIL flush_mul_no_valid got=%0d exp=0", pulses); else passed++;
        // flush beats a simultaneous accept in IDLE
        alu_op = 4'd0; exu_op_1 = 32'd1; exu_op_2 = 32'd1; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL flush_idle got ov=%b ir=%b exp ov=0 ir=1", out_valid, in_ready); else passed++;
        // flush while DONE drops out_valid without out_ready
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL flush_done got ov=%b ir=%b exp ov=0 ir=1", out_valid, in_ready); else passed++;
    endtask

    task automatic test_reset_mid_div;
        logic [31:0] res, ja;
        int lat;
        run_op(4'd0, 32'd20, 32'd22, 32'h0, 1'b0, 1'b0, res, ja, lat);
        alu_op = 4'd13; exu_op_1 = 32'd100; exu_op_2 = 32'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) $display("FAIL rst_div_out_valid got=%b exp=0", out_valid); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL rst_div_in_ready got=%b exp=1", in_ready); else passed++;
        total++; if (exu_res !== 32'h0) $display("FAIL rst_div_exu_res got=%h exp=0", exu_res); else passed++;
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        run_op(4'd0, 32'd2, 32'd3, 32'h0, 1'b0, 1'b0, res, ja, lat);
        total++; if (res !== 32'd5) $display("FAIL rst_div_recover got=%h exp=5", res); else passed++;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        test_reset;
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        test_alu;
        test_mul;
        test_div;
        test_jump;
        test_stall;
        test_flush;
        test_reset_mid_div;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
